// File: rtl/alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_sequencer
// Brief    : Iterative shift-add multiplier beside the EX-stage ALU; stalls
//            the pipeline until the low WIDTH bits of the product are ready.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_sequencer #(
    parameter int           WIDTH  = 32,
    parameter int           CNT_W  = 6,
    parameter logic [2:0]   MUL_OP = 3'b011
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mpl;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_busy;

    logic             w_start;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mpl_next;
    logic             w_last;

    assign w_start    = valid_i & (ALUCtrl_i == MUL_OP) & ~flush_i;
    assign w_acc_next = r_mpl[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mpl_next = r_mpl >> 1;
    // Stop as soon as no multiplier bits remain; the counter bounds the worst case.
    assign w_last     = (w_mpl_next == '0) || (r_cnt == c_last_iter);

    // Stall must follow the EX instruction in the same cycle so the mul is held
    // on entry and released immediately on a flush.
    assign stall_o  = rst_i & (((r_state == S_IDLE) & w_start) |
                               ((r_state == S_RUN)  & ~flush_i));
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mpl    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_mcand <= data1_i;
                        r_mpl   <= data2_i;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_mcand <= r_mcand << 1;
                        r_mpl   <= w_mpl_next;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_result <= w_acc_next;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_sequencer
// Brief    : Self-checking bench for alu_mul_sequencer (vectors + random model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_sequencer;

    localparam int WIDTH = 32;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic             flush_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_last = '0;

    alu_mul_sequencer #(
        .WIDTH  (WIDTH),
        .CNT_W  (6),
        .MUL_OP (3'b011)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] res;
        int               k;
    } vec_t;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference iteration count: index of the highest set multiplier bit plus one.
    function automatic int ref_k(input logic [WIDTH-1:0] d2);
        int k = 1;
        for (int i = 0; i < WIDTH; i++)
            if (d2[i]) k = i + 1;
        return k;
    endfunction

    // Presents a mul in IDLE, follows the stall, checks the DONE cycle.
    task automatic do_mul(input string name, input logic [WIDTH-1:0] d1,
                          input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] exp_res,
                          input int exp_k);
        int n;
        @(negedge clk_i);
        valid_i   = 1'b1;
        ALUCtrl_i = 3'b011;
        data1_i   = d1;
        data2_i   = d2;
        #1;
        check({name, ".stall_start"}, {31'd0, stall_o}, 32'd1);
        n = 1;
        forever begin
            @(negedge clk_i);
            if (!stall_o) break;
            n++;
            if (!busy_o || done_o) begin
                check({name, ".run_flags"}, {30'd0, busy_o, done_o}, 32'd2);
            end
            if (n > 40) begin
                check({name, ".timeout"}, 32'(n), 32'(exp_k + 1));
                break;
            end
        end
        check({name, ".stall_cycles"}, 32'(n), 32'(exp_k + 1));
        check({name, ".done"}, {31'd0, done_o}, 32'd1);
        check({name, ".busy_done"}, {31'd0, busy_o}, 32'd1);
        check({name, ".result"}, result_o, exp_res);
        exp_last = exp_res;
        valid_i = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        logic [WIDTH-1:0] a, b;

        vecs[0] = '{d1: 32'd6,          d2: 32'd7,          res: 32'd42,         k: 3};
        vecs[1] = '{d1: 32'hFFFF_FFFD,  d2: 32'd5,          res: 32'hFFFF_FFF1,  k: 3};
        vecs[2] = '{d1: 32'hFFFF_FFFF,  d2: 32'hFFFF_FFFF,  res: 32'h0000_0001,  k: 32};
        vecs[3] = '{d1: 32'h0000_1234,  d2: 32'd0,          res: 32'd0,          k: 1};
        vecs[4] = '{d1: 32'd1,          d2: 32'h8000_0000,  res: 32'h8000_0000,  k: 32};
        vecs[5] = '{d1: 32'd6,          d2: 32'd7,          res: 32'd42,         k: 3};

        rst_i     = 1'b0;
        valid_i   = 1'b1;
        flush_i   = 1'b0;
        ALUCtrl_i = 3'b011;
        data1_i   = 32'd3;
        data2_i   = 32'd3;
        repeat (2) @(negedge clk_i);
        check("rst.stall", {31'd0, stall_o}, 32'd0);
        check("rst.busy",  {31'd0, busy_o},  32'd0);
        check("rst.done",  {31'd0, done_o},  32'd0);
        check("rst.result", result_o, 32'd0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        for (int i = 0; i < 6; i++)
            do_mul($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].res, vecs[i].k);

        // Non-mul and invalid mul must never stall.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            valid_i   = (i < 2);
            ALUCtrl_i = (i < 2) ? 3'b010 : 3'b011;
            #1;
            check($sformatf("nomul%0d.stall", i), {31'd0, stall_o}, 32'd0);
            @(negedge clk_i);
            check($sformatf("nomul%0d.busy", i), {31'd0, busy_o}, 32'd0);
        end
        valid_i = 1'b0;

        // Flush in the second RUN cycle of 9*9.
        @(negedge clk_i);
        valid_i = 1'b1; ALUCtrl_i = 3'b011; data1_i = 32'd9; data2_i = 32'd9;
        @(negedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        valid_i = 1'b0;
        #1;
        check("flush.stall_drop", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush.busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (done_o) check("flush.no_done", {31'd0, done_o}, 32'd0);
        end
        check("flush.result_kept", result_o, exp_last);

        // Back-to-back muls, then reset during the second.
        do_mul("b2b.first", 32'd3, 32'd4, 32'd12, 3);
        @(negedge clk_i);
        valid_i = 1'b1; ALUCtrl_i = 3'b011; data1_i = 32'd5; data2_i = 32'd5;
        #1;
        check("b2b.second_start", {31'd0, stall_o}, 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("midrst.stall",  {31'd0, stall_o}, 32'd0);
        check("midrst.busy",   {31'd0, busy_o},  32'd0);
        check("midrst.done",   {31'd0, done_o},  32'd0);
        check("midrst.result", result_o, 32'd0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_last = '0;
        do_mul("post_rst", 32'd5, 32'd5, 32'd25, 3);

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_mul($sformatf("rand%0d", i), a, b, a * b, ref_k(b));
        end

        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
